// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two writeback FIFOs (ALU, MEM) round-robin arbitrated onto one registered regfile write port.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW = 5,
  parameter int DW = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          AluValid,
  output logic          AluReady,
  input  logic [AW-1:0] AluAddr,
  input  logic [DW-1:0] AluData,
  input  logic          MemValid,
  output logic          MemReady,
  input  logic [AW-1:0] MemAddr,
  input  logic [DW-1:0] MemData,
  output logic          RegWriteEN,
  output logic [AW-1:0] WriteAddr,
  output logic [DW-1:0] WriteData,
  output logic [CW-1:0] AluCount,
  output logic [CW-1:0] MemCount,
  output logic          Idle
);
  logic [AW+DW-1:0] aluFifo [DEPTH];
  logic [AW+DW-1:0] memFifo [DEPTH];
  logic [PW-1:0] aluRd, aluWr, memRd, memWr;
  logic prioMem, aluPush, memPush, grantAlu, grantMem, grant;
  logic [AW+DW-1:0] head;
  always_comb begin
    AluReady = AluCount < CW'(DEPTH);
    MemReady = MemCount < CW'(DEPTH);
    aluPush = AluValid && AluReady && AluAddr != AW'(31);
    memPush = MemValid && MemReady && MemAddr != AW'(31);
    grantAlu = AluCount != '0 && (MemCount == '0 || !prioMem);
    grantMem = MemCount != '0 && !grantAlu;
    grant = grantAlu || grantMem;
    head = grantAlu ? aluFifo[aluRd] : memFifo[memRd];
    Idle = AluCount == '0 && MemCount == '0 && !RegWriteEN;
  end
  // Payload storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (aluPush) aluFifo[aluWr] <= {AluAddr, AluData};
    if (memPush) memFifo[memWr] <= {MemAddr, MemData};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aluRd <= '0;
      aluWr <= '0;
      memRd <= '0;
      memWr <= '0;
      AluCount <= '0;
      MemCount <= '0;
      prioMem <= 1'b0;
      RegWriteEN <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
    end else begin
      if (aluPush) aluWr <= aluWr + 1'b1;
      if (grantAlu) aluRd <= aluRd + 1'b1;
      if (memPush) memWr <= memWr + 1'b1;
      if (grantMem) memRd <= memRd + 1'b1;
      AluCount <= AluCount + CW'(aluPush) - CW'(grantAlu);
      MemCount <= MemCount + CW'(memPush) - CW'(grantMem);
      if (grant) prioMem <= grantAlu;
      RegWriteEN <= grant;
      if (grant) {WriteAddr, WriteData} <= head;
    end
  end
  assert property (@(posedge clk) disable iff (!reset_n)
    !(aluPush && AluCount == CW'(DEPTH)) && !(memPush && MemCount == CW'(DEPTH)) &&
    !(grantAlu && AluCount == '0) && !(grantMem && MemCount == '0));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenario tasks for the writeback arbiter.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2, AW = 5, DW = 64, CW = 2;
  logic clk = 1'b0, reset_n = 1'b0;
  logic AluValid = 1'b0, MemValid = 1'b0;
  logic [AW-1:0] AluAddr = '0, MemAddr = '0;
  logic [DW-1:0] AluData = '0, MemData = '0;
  logic AluReady, MemReady, RegWriteEN, Idle;
  logic [AW-1:0] WriteAddr;
  logic [DW-1:0] WriteData;
  logic [CW-1:0] AluCount, MemCount;
  int checks = 0, errors = 0;
  logic [AW+DW-1:0] wlog [$];

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .AluValid(AluValid), .AluReady(AluReady), .AluAddr(AluAddr), .AluData(AluData),
    .MemValid(MemValid), .MemReady(MemReady), .MemAddr(MemAddr), .MemData(MemData),
    .RegWriteEN(RegWriteEN), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .AluCount(AluCount), .MemCount(MemCount), .Idle(Idle)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (reset_n && RegWriteEN) wlog.push_back({WriteAddr, WriteData});

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!Idle && n < 30) begin
      @(negedge clk);
      n++;
    end
    #1;
    checks++;
    if (!Idle) begin errors++; $display("FAIL drain_timeout: Idle=%0b required 1", Idle); end
  endtask

  task automatic stream(input int nA, input int nM, input int bA, input int bM, output bit sawFull);
    int ia = 0, im = 0, cyc = 0;
    bit fa, fm;
    sawFull = 0;
    while ((ia < nA || im < nM) && cyc < 100) begin
      @(negedge clk);
      AluValid = ia < nA; AluAddr = AW'(bA + ia); AluData = DW'(bA + ia);
      MemValid = im < nM; MemAddr = AW'(bM + im); MemData = DW'(bM + im);
      #1;
      checks++;
      if (MemReady !== (MemCount < CW'(DEPTH))) begin
        errors++; $display("FAIL mem_ready: MemReady=%0b with MemCount=%0d", MemReady, MemCount);
      end
      if (MemCount == CW'(DEPTH)) sawFull = 1;
      fa = AluValid && AluReady;
      fm = MemValid && MemReady;
      @(posedge clk);
      if (fa) ia++;
      if (fm) im++;
      cyc++;
    end
    @(negedge clk);
    AluValid = 0; MemValid = 0;
    checks++;
    if (cyc >= 100) begin errors++; $display("FAIL stream_timeout: sent alu %0d mem %0d", ia, im); end
    wait_idle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({RegWriteEN, WriteAddr, WriteData} !== '0) begin
      errors++; $display("FAIL reset_out: en=%0b addr=%0d data=%0h required 0", RegWriteEN, WriteAddr, WriteData);
    end
    checks++;
    if (AluCount !== 0 || MemCount !== 0) begin
      errors++; $display("FAIL reset_count: alu=%0d mem=%0d required 0", AluCount, MemCount);
    end
    checks++;
    if ({Idle, AluReady, MemReady} !== 3'b111) begin
      errors++; $display("FAIL reset_flags: idle/aluRdy/memRdy=%b required 111", {Idle, AluReady, MemReady});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    wlog.delete();
    @(negedge clk);
    AluValid = 1; AluAddr = 5; AluData = 64'hA5;
    #1;
    checks++;
    if (AluReady !== 1'b1) begin errors++; $display("FAIL single_ready: %0b required 1", AluReady); end
    @(negedge clk);
    AluValid = 0;
    #1;
    checks++;
    if (RegWriteEN !== 1'b0 || AluCount !== 1) begin
      errors++; $display("FAIL single_n: en=%0b count=%0d required en=0 count=1", RegWriteEN, AluCount);
    end
    @(negedge clk);
    #1;
    checks++;
    if (RegWriteEN !== 1'b1 || WriteAddr !== 5 || WriteData !== 64'hA5 || Idle !== 1'b0) begin
      errors++; $display("FAIL single_write: en=%0b addr=%0d data=%0h idle=%0b required 1/5/a5/0", RegWriteEN, WriteAddr, WriteData, Idle);
    end
    @(negedge clk);
    #1;
    checks++;
    if (RegWriteEN !== 1'b0 || Idle !== 1'b1 || WriteAddr !== 5 || WriteData !== 64'hA5) begin
      errors++; $display("FAIL single_after: en=%0b idle=%0b addr=%0d data=%0h required 0/1/5/a5", RegWriteEN, Idle, WriteAddr, WriteData);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wlog.size() != 1) begin errors++; $display("FAIL single_once: %0d writes required 1", wlog.size()); end
  endtask

  task automatic test_alternate();
    bit full;
    logic [AW+DW-1:0] e;
    pulse_reset();
    wlog.delete();
    stream(4, 4, 1, 11, full);
    checks++;
    if (wlog.size() != 8) begin errors++; $display("FAIL alt_count: %0d writes required 8", wlog.size()); end
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      e = (i % 2 == 0) ? {AW'(1 + i / 2), DW'(1 + i / 2)} : {AW'(11 + i / 2), DW'(11 + i / 2)};
      checks++;
      if (wlog[i] !== e) begin errors++; $display("FAIL alt_order[%0d]: got %0h required %0h", i, wlog[i], e); end
    end
  endtask

  task automatic test_back_to_back();
    bit full;
    int na = 0, nm = 0;
    wlog.delete();
    stream(6, 6, 1, 16, full);
    checks++;
    if (!full) begin errors++; $display("FAIL b2b_full: MemCount never reached %0d", DEPTH); end
    foreach (wlog[i]) begin
      if (wlog[i][AW+DW-1:DW] >= 16) begin
        checks++;
        if (wlog[i] !== {AW'(16 + nm), DW'(16 + nm)}) begin
          errors++; $display("FAIL b2b_mem[%0d]: got %0h required data %0d", nm, wlog[i], 16 + nm);
        end
        nm++;
      end else begin
        checks++;
        if (wlog[i] !== {AW'(1 + na), DW'(1 + na)}) begin
          errors++; $display("FAIL b2b_alu[%0d]: got %0h required data %0d", na, wlog[i], 1 + na);
        end
        na++;
      end
    end
    checks++;
    if (na != 6 || nm != 6) begin errors++; $display("FAIL b2b_total: alu %0d mem %0d required 6/6", na, nm); end
  endtask

  task automatic test_x31();
    wlog.delete();
    @(negedge clk);
    AluValid = 1; AluAddr = 31; AluData = 64'hFF;
    #1;
    checks++;
    if (AluReady !== 1'b1) begin errors++; $display("FAIL x31_ready: %0b required 1", AluReady); end
    @(negedge clk);
    AluValid = 0;
    #1;
    checks++;
    if (AluCount !== 0) begin errors++; $display("FAIL x31_count: %0d required 0", AluCount); end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (wlog.size() != 0 || Idle !== 1'b1) begin
      errors++; $display("FAIL x31_nowrite: writes=%0d idle=%0b required 0/1", wlog.size(), Idle);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    AluValid = 1; AluAddr = 1; AluData = 64'h31;
    MemValid = 1; MemAddr = 2; MemData = 64'h32;
    @(negedge clk);
    AluAddr = 3; AluData = 64'h33;
    MemAddr = 4; MemData = 64'h34;
    @(negedge clk);
    AluValid = 0; MemValid = 0;
    #1;
    checks++;
    if (AluCount + MemCount !== 3 || RegWriteEN !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: queued=%0d en=%0b required 3/1", AluCount + MemCount, RegWriteEN);
    end
    #1;
    reset_n = 0;
    #1;
    checks++;
    if (RegWriteEN !== 1'b0 || AluCount !== 0 || MemCount !== 0 || WriteAddr !== 0) begin
      errors++; $display("FAIL midrst_async: en=%0b alu=%0d mem=%0d addr=%0d required 0", RegWriteEN, AluCount, MemCount, WriteAddr);
    end
    checks++;
    if ({Idle, AluReady, MemReady} !== 3'b111) begin
      errors++; $display("FAIL midrst_flags: %b required 111", {Idle, AluReady, MemReady});
    end
    @(negedge clk);
    reset_n = 1;
    wlog.delete();
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (wlog.size() != 0) begin errors++; $display("FAIL midrst_quiet: %0d writes required 0", wlog.size()); end
    @(negedge clk);
    AluValid = 1; AluAddr = 7; AluData = 64'h77;
    @(negedge clk);
    AluValid = 0;
    wait_idle();
    checks++;
    if (wlog.size() != 1 || wlog[0] !== {AW'(7), DW'(64'h77)}) begin
      errors++; $display("FAIL midrst_new: writes=%0d first=%0h required 1 entry {7,77}", wlog.size(), wlog.size() ? wlog[0] : '0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_back_to_back();
    test_x31();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
